// File: rtl/brightness_pkg.sv
// brightness_pkg
// Shared constants and types for the auto-brightness statistics path:
//   - BT.601-style integer luma coefficients (sum of the three is 256)
//   - LEVEL_NEUTRAL: brightness level that leaves pixels unchanged
//   - abc_state_t: control FSM states of auto_brightness_ctrl
package brightness_pkg;

  localparam logic [7:0] LUMA_COEF_R   = 8'd77;
  localparam logic [7:0] LUMA_COEF_G   = 8'd150;
  localparam logic [7:0] LUMA_COEF_B   = 8'd29;
  localparam logic [7:0] LEVEL_NEUTRAL = 8'd128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_ADJUST
  } abc_state_t;

endpackage

// File: rtl/seq_udiv.sv
// seq_udiv
// Sequential restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             load operands and begin (ignored results of any run in flight)
//   dividend          DIVIDEND_W-bit numerator
//   divisor           DIVISOR_W-bit denominator (caller guarantees non-zero)
//   quotient          low QUOT_W bits of the truncated quotient, held until next start
//   done              one-cycle pulse exactly DIVIDEND_W cycles after start
module seq_udiv #(
  parameter int DIVIDEND_W = 30,
  parameter int DIVISOR_W  = 22,
  parameter int QUOT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  done
);

  localparam int ITER_W = $clog2(DIVIDEND_W + 1);

  // quo_q starts as the dividend and is shifted left each step; quotient
  // bits enter at the bottom as dividend bits leave at the top.
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVISOR_W-1:0]  dsr_q;
  logic [ITER_W-1:0]     iter_q;
  logic                  busy_q;
  logic                  done_q;

  logic [DIVISOR_W:0]    rem_shift;
  logic [DIVISOR_W+1:0]  trial;
  logic                  fits;

  // The remainder is always below the divisor, so after the shift it needs
  // one extra bit; one more bit on the trial catches the borrow.
  assign rem_shift = {rem_q, quo_q[DIVIDEND_W-1]};
  assign trial     = {1'b0, rem_shift} - {2'b00, dsr_q};
  assign fits      = ~trial[DIVISOR_W+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      dsr_q  <= divisor;
      iter_q <= ITER_W'(DIVIDEND_W);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      quo_q  <= {quo_q[DIVIDEND_W-2:0], fits};
      rem_q  <= fits ? DIVISOR_W'(trial) : DIVISOR_W'(rem_shift);
      iter_q <= iter_q - ITER_W'(1);
      if (iter_q == ITER_W'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign quotient = quo_q[QUOT_W-1:0];
  assign done     = done_q;

endmodule

// File: rtl/auto_brightness_ctrl.sv
// auto_brightness_ctrl
// Measures mean luma per frame and steps the brightness level toward a
// programmable target, once per frame, with a deadband.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   r_in, g_in, b_in         pixel components
//   data_valid               pixel qualifier
//   frame_end                one-cycle pulse; may coincide with the last pixel
//   target_luma              desired mean luma (sampled when the level updates)
//   auto_enable              closed-loop enable
//   brightness_level         level to the brightness stage, 128 = neutral
//   brightness_enable        registered copy of auto_enable
//   frame_luma               last measured mean luma
//   luma_valid               pulse when frame_luma / brightness_level update
//   frame_dropped            pulse when a frame's statistics were discarded
module auto_brightness_ctrl
  import brightness_pkg::*;
#(
  parameter int CNT_W    = 22,
  parameter int STEP     = 4,
  parameter int DEADBAND = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic       data_valid,
  input  logic       frame_end,
  input  logic [7:0] target_luma,
  input  logic       auto_enable,
  output logic [7:0] brightness_level,
  output logic       brightness_enable,
  output logic [7:0] frame_luma,
  output logic       luma_valid,
  output logic       frame_dropped
);

  localparam int SUM_W = CNT_W + 8;
  localparam logic signed [8:0] DB     = 9'(DEADBAND);
  localparam logic [7:0]        STEP_B = 8'(STEP);

  // Luma stage
  logic [15:0] y_sum;
  logic [7:0]  y_l;
  logic        valid_l;
  logic        fe_l;

  assign y_sum = 16'(LUMA_COEF_R) * 16'(r_in)
               + 16'(LUMA_COEF_G) * 16'(g_in)
               + 16'(LUMA_COEF_B) * 16'(b_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_l     <= '0;
      valid_l <= 1'b0;
      fe_l    <= 1'b0;
    end else begin
      y_l     <= 8'(y_sum >> 8);
      valid_l <= data_valid;
      fe_l    <= frame_end;
    end
  end

  // Accumulators. The snapshot folds in a pixel that arrives together with
  // frame_end; a saturated count freezes both sum and count.
  logic [SUM_W-1:0] acc_sum;
  logic [CNT_W-1:0] acc_cnt;
  logic [SUM_W-1:0] snap_sum;
  logic [CNT_W-1:0] snap_cnt;
  logic             take;

  assign take     = valid_l && (acc_cnt != {CNT_W{1'b1}});
  assign snap_sum = acc_sum + (take ? SUM_W'(y_l) : '0);
  assign snap_cnt = acc_cnt + (take ? CNT_W'(1) : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum <= '0;
      acc_cnt <= '0;
    end else if (fe_l) begin
      acc_sum <= '0;
      acc_cnt <= '0;
    end else if (take) begin
      acc_sum <= snap_sum;
      acc_cnt <= snap_cnt;
    end
  end

  // Mean = sum / count
  logic       div_start;
  logic       div_done;
  logic [7:0] quotient;

  seq_udiv #(
    .DIVIDEND_W(SUM_W),
    .DIVISOR_W (CNT_W),
    .QUOT_W    (8)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(snap_sum),
    .divisor (snap_cnt),
    .quotient(quotient),
    .done    (div_done)
  );

  // Level step candidates. The error is taken as mean - target, which
  // always fits 9-bit signed, instead of forming target +/- DEADBAND.
  logic signed [8:0] diff;
  logic [8:0]        level_up;
  logic [7:0]        level_inc;
  logic [7:0]        level_dec;

  assign diff      = $signed({1'b0, quotient}) - $signed({1'b0, target_luma});
  assign level_up  = {1'b0, brightness_level} + {1'b0, STEP_B};
  assign level_inc = level_up[8] ? 8'hFF : level_up[7:0];
  assign level_dec = (brightness_level < STEP_B) ? 8'd0 : brightness_level - STEP_B;

  // Control FSM
  abc_state_t state_q;
  abc_state_t state_next;
  logic [7:0] level_next;
  logic [7:0] luma_next;
  logic       valid_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    div_start  = 1'b0;
    level_next = brightness_level;
    luma_next  = frame_luma;
    valid_next = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fe_l && (snap_cnt != '0)) begin
          div_start  = 1'b1;
          state_next = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (div_done) state_next = ST_ADJUST;
      end
      ST_ADJUST: begin
        luma_next  = quotient;
        valid_next = 1'b1;
        if (!auto_enable)    level_next = LEVEL_NEUTRAL;
        else if (diff < -DB) level_next = level_inc;
        else if (diff > DB)  level_next = level_dec;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output registers. A frame ending while the previous one is still being
  // processed is flagged one cycle later so the pulse lands two edges after
  // frame_end is sampled.
  logic drop_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brightness_level  <= LEVEL_NEUTRAL;
      frame_luma        <= '0;
      luma_valid        <= 1'b0;
      brightness_enable <= 1'b0;
      drop_pend         <= 1'b0;
      frame_dropped     <= 1'b0;
    end else begin
      brightness_level  <= level_next;
      frame_luma        <= luma_next;
      luma_valid        <= valid_next;
      brightness_enable <= auto_enable;
      drop_pend         <= fe_l && (state_q != ST_IDLE);
      frame_dropped     <= drop_pend;
    end
  end

endmodule
